// File: rtl/parity_tx_pkg.sv
// Shared types and constants for the parity frame transmitter.
package parity_tx_pkg;

  localparam int unsigned DATA_W     = 4;
  localparam int unsigned FRAME_BITS = 7;
  localparam logic        TX_IDLE    = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

endpackage

// File: rtl/Parity_Gene.sv
// 4-input even-parity generator: e is high when a..d hold an odd number of ones.
module Parity_Gene (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic e
);

  assign e = a ^ b ^ c ^ d;

endmodule

// File: rtl/parity_frame_tx.sv
// Two-requester serial frame transmitter: round-robin word accept, shared parity
// generator, 7-bit frame (start, 4 data LSB-first, parity, stop) on tx.
module parity_frame_tx
  import parity_tx_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt1,
  output logic              tx,
  output logic              busy,
  output logic              src,
  output logic              par
);

  localparam int unsigned      CNT_W    = $clog2(BIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  // Index of the last data bit: frame minus start, parity and stop, minus one.
  localparam logic [1:0]       IDX_LAST = 2'(FRAME_BITS - 4);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        idx_q;
  logic [DATA_W-1:0] shift_q;
  logic              ptr_q;
  logic              gnt0_q;
  logic              gnt1_q;
  logic              tx_q;
  logic              busy_q;
  logic              src_q;
  logic              par_q;

  logic [DATA_W-1:0] word_mux;
  logic              par_gen;
  logic              bit_end;
  logic              arb_en;
  logic              win1;

  // Granted word feeds the single parity generator during the grant cycle.
  assign word_mux = gnt1_q ? data1 : data0;

  Parity_Gene u_parity_gene (
    .a (word_mux[3]),
    .b (word_mux[2]),
    .c (word_mux[1]),
    .d (word_mux[0]),
    .e (par_gen)
  );

  assign bit_end = (cnt_q == CNT_LAST);

  // Arbitrate in the cycle before an IDLE cycle, so the registered gnt lands in IDLE.
  assign arb_en = ((state_q == IDLE) && !gnt0_q && !gnt1_q) ||
                  ((state_q == STOP) && bit_end);

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign win1 = req1 && (!req0 || !ptr_q);

  // Arbiter, frame FSM, bit timing and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      ptr_q   <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      tx_q    <= TX_IDLE;
      busy_q  <= 1'b0;
      src_q   <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      if (arb_en && (req0 || req1)) begin
        gnt0_q <= !win1;
        gnt1_q <= win1;
        ptr_q  <= win1;
      end

      cnt_q <= bit_end ? '0 : cnt_q + 1'b1;

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (gnt0_q || gnt1_q) begin
            state_q <= START;
            shift_q <= word_mux;
            par_q   <= par_gen;
            src_q   <= gnt1_q;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (idx_q == IDX_LAST) begin
              state_q <= PARITY;
              tx_q    <= par_q;
            end else begin
              idx_q   <= idx_q + 1'b1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            tx_q    <= TX_IDLE;
          end
        end
        STOP: begin
          if (bit_end) begin
            state_q <= IDLE;
            tx_q    <= TX_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= TX_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign tx   = tx_q;
  assign busy = busy_q;
  assign src  = src_q;
  assign par  = par_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: two instances (4 and 1 cycles per bit) share stimulus;
// a frame-level model predicts every output each cycle, plus literal spot checks.
module tb_parity_frame_tx;
  import parity_tx_pkg::*;

  localparam int unsigned B0 = 4;
  localparam int unsigned B1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              req0;
  logic              req1;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic              gnt0_w [2];
  logic              gnt1_w [2];
  logic              tx_w   [2];
  logic              busy_w [2];
  logic              src_w  [2];
  logic              par_w  [2];

  parity_frame_tx #(.BIT_CYCLES(B0)) dut0 (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .data0 (data0),
    .gnt0  (gnt0_w[0]),
    .req1  (req1),
    .data1 (data1),
    .gnt1  (gnt1_w[0]),
    .tx    (tx_w[0]),
    .busy  (busy_w[0]),
    .src   (src_w[0]),
    .par   (par_w[0])
  );

  parity_frame_tx #(.BIT_CYCLES(B1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .data0 (data0),
    .gnt0  (gnt0_w[1]),
    .req1  (req1),
    .data1 (data1),
    .gnt1  (gnt1_w[1]),
    .tx    (tx_w[1]),
    .busy  (busy_w[1]),
    .src   (src_w[1]),
    .par   (par_w[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Frame-level reference: a grant at cycle T makes cycles T+1..T+7B carry the frame
  // bits, B cycles each; a new grant may be decided once the frame has reached its
  // last cycle (or none is active), lands one cycle later.
  bit          m_act  [2];
  int          m_k    [2];
  bit          m_win  [2];
  bit          m_ptr  [2] = '{1'b1, 1'b1};
  bit          m_src  [2];
  bit          m_par  [2];
  logic [6:0]  m_bits [2];

  initial begin
    int          b;
    logic        e_busy;
    logic        e_tx;
    logic        e_g0;
    logic        e_g1;
    logic [3:0]  w;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        b      = (i == 0) ? B0 : B1;
        e_busy = m_act[i] && (m_k[i] >= 1) && (m_k[i] <= 7 * b);
        e_tx   = e_busy ? m_bits[i][3'((m_k[i] - 1) / b)] : 1'b1;
        e_g0   = m_act[i] && (m_k[i] == 0) && !m_win[i];
        e_g1   = m_act[i] && (m_k[i] == 0) && m_win[i];
        chk($sformatf("dut%0d gnt0", i), 32'(gnt0_w[i]), 32'(e_g0));
        chk($sformatf("dut%0d gnt1", i), 32'(gnt1_w[i]), 32'(e_g1));
        chk($sformatf("dut%0d busy", i), 32'(busy_w[i]), 32'(e_busy));
        chk($sformatf("dut%0d tx", i),   32'(tx_w[i]),   32'(e_tx));
        chk($sformatf("dut%0d src", i),  32'(src_w[i]),  32'(m_src[i]));
        chk($sformatf("dut%0d par", i),  32'(par_w[i]),  32'(m_par[i]));

        if (rst) begin
          m_act[i] = 1'b0;
          m_ptr[i] = 1'b1;
          m_src[i] = 1'b0;
          m_par[i] = 1'b0;
        end else begin
          if (m_act[i] && m_k[i] == 0) begin
            w         = m_win[i] ? data1 : data0;
            m_par[i]  = ($countones(w) % 2) == 1;
            m_src[i]  = m_win[i];
            m_bits[i] = {1'b1, m_par[i], w, 1'b0};
          end
          if ((!m_act[i] || m_k[i] >= 7 * b) && (req0 || req1)) begin
            m_win[i] = (req0 && req1) ? !m_ptr[i] : req1;
            m_ptr[i] = m_win[i];
            m_act[i] = 1'b1;
            m_k[i]   = 0;
          end else if (m_act[i] && m_k[i] <= 7 * b) begin
            m_k[i]++;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int inst, input bit which, input int limit, input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < limit && !seen; c++) begin
      @(negedge clk);
      seen = ((which ? gnt1_w[inst] : gnt0_w[inst]) === 1'b1);
    end
    chk({name, " grant seen"}, 32'(seen), 32'd1);
  endtask

  task automatic send0(input logic [3:0] d, input logic exp_par, input string name);
    @(posedge clk); #1;
    data0 = d;
    req0  = 1'b1;
    wait_gnt(0, 1'b0, 80, name);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    chk({name, " par"}, 32'(par_w[0]), 32'(exp_par));
    chk({name, " src"}, 32'(src_w[0]), 32'd0);
  endtask

  initial begin
    int          t0;
    int          t1;
    int          t2;
    int          cnt;
    int          r;
    logic [27:0] v;

    rst   = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    data0 = '0;
    data1 = '0;
    tick(3);
    @(negedge clk);
    chk("reset tx",   32'(tx_w[0]),   32'd1);
    chk("reset busy", 32'(busy_w[0]), 32'd0);
    chk("reset gnt0", 32'(gnt0_w[0]), 32'd0);
    chk("reset gnt1", 32'(gnt1_w[0]), 32'd0);
    chk("reset src",  32'(src_w[0]),  32'd0);
    chk("reset par",  32'(par_w[0]),  32'd0);

    // Single word 1011 at 4 cycles per bit.
    @(posedge clk); #1;
    rst   = 1'b0;
    req0  = 1'b1;
    data0 = 4'b1011;
    wait_gnt(0, 1'b0, 4, "single");
    @(posedge clk); #1;
    req0 = 1'b0;
    v   = '0;
    cnt = 0;
    @(negedge clk);
    for (int s = 0; s < 28; s++) begin
      v[s] = tx_w[0];
      if (busy_w[0] === 1'b1) cnt++;
      if (s < 27) @(negedge clk);
    end
    chk("single tx bits", 32'(v), 32'h0FFF0FF0);
    chk("single busy len", 32'(cnt), 32'd28);
    chk("single par", 32'(par_w[0]), 32'd1);
    @(negedge clk);
    chk("single end busy", 32'(busy_w[0]), 32'd0);
    chk("single end tx", 32'(tx_w[0]), 32'd1);

    // Tie: both held after reset; requester 0 first, then alternate every 29 cycles.
    @(posedge clk); #1;
    rst = 1'b1;
    tick(2);
    rst   = 1'b0;
    req0  = 1'b1;
    req1  = 1'b1;
    data0 = 4'h5;
    data1 = 4'hA;
    wait_gnt(0, 1'b0, 5, "tie first");
    t0 = cyc;
    @(negedge clk);
    chk("tie src 0", 32'(src_w[0]), 32'd0);
    wait_gnt(0, 1'b1, 40, "tie second");
    t1 = cyc;
    chk("tie gap 1", 32'(t1 - t0), 32'd29);
    @(negedge clk);
    chk("tie src 1", 32'(src_w[0]), 32'd1);
    wait_gnt(0, 1'b0, 40, "tie third");
    t2 = cyc;
    chk("tie gap 2", 32'(t2 - t1), 32'd29);
    @(negedge clk);
    chk("tie src 2", 32'(src_w[0]), 32'd0);
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;

    // Parity corners.
    send0(4'b0000, 1'b0, "par 0000");
    send0(4'b1111, 1'b0, "par 1111");
    send0(4'b0001, 1'b1, "par 0001");

    // Reset during data bit 2 with requester 1 pending.
    @(posedge clk); #1;
    data0 = 4'b0110;
    req0  = 1'b1;
    wait_gnt(0, 1'b0, 80, "midrst frame");
    @(posedge clk); #1;
    req0  = 1'b0;
    req1  = 1'b1;
    data1 = 4'b1001;
    tick(13);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst bit2 tx", 32'(tx_w[0]), 32'd1);
    chk("midrst bit2 busy", 32'(busy_w[0]), 32'd1);
    tick(1);
    @(negedge clk);
    chk("midrst tx", 32'(tx_w[0]), 32'd1);
    chk("midrst busy", 32'(busy_w[0]), 32'd0);
    chk("midrst gnt0", 32'(gnt0_w[0]), 32'd0);
    chk("midrst gnt1", 32'(gnt1_w[0]), 32'd0);
    tick(1);
    rst = 1'b0;
    r   = cyc;
    wait_gnt(0, 1'b1, 3, "midrst regrant");
    chk("midrst regrant delay", 32'(cyc - r), 32'd1);

    // Withdrawn request while busy.
    @(posedge clk); #1;
    req1 = 1'b0;
    tick(5);
    req1 = 1'b1;
    tick(3);
    req1 = 1'b0;
    cnt = 0;
    t0  = 0;
    for (int s = 0; s < 50; s++) begin
      @(negedge clk);
      if (busy_w[0] === 1'b1) cnt++;
      if (gnt1_w[0] === 1'b1 || gnt0_w[0] === 1'b1) t0++;
    end
    chk("withdraw busy len", 32'(cnt), 32'd20);
    chk("withdraw no gnt", 32'(t0), 32'd0);
    chk("withdraw tx idle", 32'(tx_w[0]), 32'd1);

    // Random traffic checked by the model.
    for (int s = 0; s < 1500; s++) begin
      @(posedge clk); #1;
      rst   = ($urandom_range(0, 149) == 0);
      req0  = ($urandom_range(0, 3) != 0);
      req1  = ($urandom_range(0, 2) != 0);
      data0 = 4'($urandom);
      data1 = 4'($urandom);
    end

    // One cycle per bit with requester 0 held.
    @(posedge clk); #1;
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    tick(1);
    rst   = 1'b0;
    req0  = 1'b1;
    data0 = 4'b0011;
    wait_gnt(1, 1'b0, 4, "fast first");
    for (int p = 0; p < 2; p++) begin
      t0  = cyc;
      cnt = 0;
      t1  = 0;
      for (int s = 0; s < 20 && t1 == 0; s++) begin
        @(negedge clk);
        if (busy_w[1] === 1'b1) cnt++;
        if (gnt0_w[1] === 1'b1) t1 = cyc;
      end
      chk($sformatf("fast period %0d", p), 32'(t1 - t0), 32'd8);
      chk($sformatf("fast busy %0d", p), 32'(cnt), 32'd7);
    end
    @(posedge clk); #1;
    req0 = 1'b0;
    tick(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
